mem_port_arbiter: RTL and testbench

- Shares one variable-latency backing memory port between the instruction-fetch requester (IF, read-only) and the data-access requester (ME, read/write).
- Sits between the pipeline and the unified memory/cache.
- Arbitrates with ME-first priority and an IF anti-starvation limit.
- Latches the granted request, runs a req/ack transaction, then returns data with a one-cycle done pulse. The pipeline uses the done pulses as stall release.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch (IF) and data access (ME).
// ME wins by default; IF is forced through after MAX_ME_STREAK consecutive ME grants while it waits.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_ME_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,

    input  logic                me_req,
    input  logic                me_we,
    input  logic [DATA_W/8-1:0] me_wstrb,
    input  logic [ADDR_W-1:0]   me_addr,
    input  logic [DATA_W-1:0]   me_wdata,
    output logic [DATA_W-1:0]   me_rdata,
    output logic                me_done,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy,
    output logic                owner
);

    // state  | meaning
    // IDLE   | arbitrate between IF and ME, latch the winner onto mem_*
    // XFER   | mem_req held with stable payload until mem_ack
    // RESP   | one cycle carrying the done pulse, no arbitration
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          STRB_W     = DATA_W / 8;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_ME_STREAK);

    state_t              r_state;
    logic [3:0]          r_streak;
    logic                r_killed;
    logic                r_owner;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_me_rdata;
    logic                r_if_done;
    logic                r_me_done;

    logic                w_if_elig;
    logic                w_streak_max;
    logic                w_grant_me;
    logic                w_grant_if;
    logic                w_if_killed;

    assign w_if_elig    = if_req & ~if_kill;
    assign w_streak_max = (r_streak == STREAK_MAX);
    assign w_grant_me   = me_req & ~(w_if_elig & w_streak_max);
    assign w_grant_if   = w_if_elig & ~w_grant_me;
    // A kill arriving in the same cycle as the ack must also suppress the fetch result.
    assign w_if_killed  = r_killed | if_kill;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_killed    <= 1'b0;
            r_owner     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_me_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_me_done   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_me_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_me) begin
                        r_owner     <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= me_we;
                        r_mem_wstrb <= me_wstrb;
                        r_mem_addr  <= me_addr;
                        r_mem_wdata <= me_wdata;
                        r_state     <= ST_XFER;
                        if (!w_if_elig)
                            r_streak <= '0;
                        else if (!w_streak_max)
                            r_streak <= r_streak + 4'd1;
                    end else if (w_grant_if) begin
                        r_owner     <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= '0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_streak    <= '0;
                        r_state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!r_owner && if_kill)
                        r_killed <= 1'b1;
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_killed  <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_owner) begin
                            r_me_rdata <= mem_rdata;
                            r_me_done  <= 1'b1;
                        end else if (!w_if_killed) begin
                            r_if_rdata <= mem_rdata;
                            r_if_done  <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign me_rdata  = r_me_rdata;
    assign if_done   = r_if_done;
    assign me_done   = r_me_done;
    assign owner     = r_owner;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, streak limit, kill, reset abort, zero-wait memory.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                if_req, if_kill;
    logic [ADDR_W-1:0]   if_addr;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_done;
    logic                me_req, me_we;
    logic [DATA_W/8-1:0] me_wstrb;
    logic [ADDR_W-1:0]   me_addr;
    logic [DATA_W-1:0]   me_wdata;
    logic [DATA_W-1:0]   me_rdata;
    logic                me_done;
    logic                mem_req, mem_we;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy, owner;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ME_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done),
        .me_req(me_req), .me_we(me_we), .me_wstrb(me_wstrb), .me_addr(me_addr),
        .me_wdata(me_wdata), .me_rdata(me_rdata), .me_done(me_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_seq;
        int         ng;

        rst = 1'b0; if_req = 0; if_kill = 0; if_addr = '0;
        me_req = 0; me_we = 0; me_wstrb = '0; me_addr = '0; me_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        step(); step();
        check("rst_mem_req", mem_req, 0);
        check("rst_busy",    busy,    0);
        check("rst_owner",   owner,   0);
        check("rst_addr",    mem_addr, 0);
        check("rst_dones",   {if_done, me_done}, 0);
        rst = 1'b1;
        step();

        // IF only, ack two cycles after mem_req rises
        if_req = 1; if_addr = 32'h100;
        step();
        check("t1_mem_req", mem_req, 1);
        check("t1_addr",    mem_addr, 32'h100);
        check("t1_we",      mem_we, 0);
        check("t1_owner",   owner, 0);
        check("t1_busy",    busy, 1);
        step();
        check("t1_hold1", mem_req, 1);
        step();
        check("t1_hold2", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'h00500093;
        step();
        check("t1_if_done", if_done, 1);
        check("t1_rdata",   if_rdata, 32'h00500093);
        check("t1_me_done", me_done, 0);
        check("t1_req_off", mem_req, 0);
        if_req = 0; mem_ack = 0;
        step();
        check("t1_done_pulse", if_done, 0);
        check("t1_idle", busy, 0);

        // simultaneous IF/ME, zero-wait memory: ME first, IF issued 3 cycles later
        if_req = 1; if_addr = 32'h200;
        me_req = 1; me_we = 1; me_addr = 32'h20; me_wdata = 32'hDEADBEEF; me_wstrb = 4'b0011;
        mem_ack = 1; mem_rdata = 32'h12345678;
        step();
        check("t2_me_owner", owner, 1);
        check("t2_me_we",    mem_we, 1);
        check("t2_me_addr",  mem_addr, 32'h20);
        check("t2_me_wstrb", mem_wstrb, 4'b0011);
        check("t2_me_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        check("t2_me_done",  me_done, 1);
        check("t2_if_quiet", if_done, 0);
        me_req = 0;
        step();
        check("t2_gap_req",  mem_req, 0);
        check("t2_gap_done", me_done, 0);
        step();
        check("t2_if_req",   mem_req, 1);
        check("t2_if_owner", owner, 0);
        check("t2_if_addr",  mem_addr, 32'h200);
        check("t2_if_we",    {mem_we, mem_wstrb}, 0);
        step();
        check("t2_if_done",  if_done, 1);
        check("t2_if_rdata", if_rdata, 32'h12345678);
        if_req = 0;
        step();

        // both held: ME x4, IF, ME x4, IF
        me_we = 0; me_addr = 32'h40; me_wstrb = '0;
        if_req = 1; me_req = 1; mem_ack = 1;
        exp_seq = 10'b0111101111;
        ng = 0;
        for (int i = 0; i < 60 && ng < 10; i++) begin
            step();
            if (mem_req) begin
                check($sformatf("t3_grant%0d", ng), owner, exp_seq[ng]);
                ng++;
            end
        end
        check("t3_grant_count", ng, 10);
        if_req = 0; me_req = 0;
        step(); step(); step(); step();
        check("t3_idle", busy, 0);

        // kill during an IF transfer
        mem_ack = 0; mem_rdata = 32'hCAFEF00D;
        if_req = 1; if_addr = 32'h300;
        step();
        check("t4_xfer", mem_req, 1);
        if_kill = 1;
        step();
        if_kill = 0; if_req = 0;
        check("t4_hold1", mem_req, 1);
        step();
        check("t4_hold2", mem_req, 1);
        step();
        check("t4_hold3", mem_req, 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        check("t4_no_done", if_done, 0);
        check("t4_rdata",   if_rdata, 32'h12345678);
        check("t4_resp",    {busy, mem_req}, 2'b10);
        step();
        check("t4_no_done2", if_done, 0);
        check("t4_idle",     busy, 0);

        // reset mid-transfer
        me_req = 1; me_we = 0; me_addr = 32'h40;
        step();
        check("t5_xfer", mem_req, 1);
        rst = 0; me_req = 0;
        step();
        check("t5_req_off", mem_req, 0);
        check("t5_busy",    busy, 0);
        check("t5_outs",    {if_done, me_done, owner}, 0);
        check("t5_rdata",   {if_rdata, me_rdata}, 0);
        rst = 1; mem_ack = 1;
        step();
        check("t5_no_done1", {if_done, me_done}, 0);
        step();
        check("t5_no_done2", {if_done, me_done}, 0);

        // zero-wait ME after reset: single transaction, done 2 cycles after request
        me_req = 1; me_we = 1; me_addr = 32'h44; me_wdata = 32'h55AA55AA; me_wstrb = 4'hF;
        mem_rdata = 32'h0BADF00D;
        step();
        check("t6_req",   mem_req, 1);
        check("t6_owner", owner, 1);
        check("t6_addr",  mem_addr, 32'h44);
        step();
        check("t6_done",  me_done, 1);
        check("t6_rdata", me_rdata, 32'h0BADF00D);
        me_req = 0;
        step();
        check("t6_resp_nogrant", {mem_req, me_done}, 0);
        step();
        check("t6_no_dup", mem_req, 0);
        check("t6_idle",   busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
